ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave that accepts transfers from the bus master and converts them into accesses on a single-port synchronous SRAM (1-cycle read latency).
- Sits directly downstream of the bus master; its ahb_readyo/ahb_rdata feed back to the master's ready/read-data inputs.
- Zero-wait-state reads and writes, except one wait state when a read address phase collides with a preceding write data phase.

Parameters:
AW, 10, SRAM word-address width; SRAM depth = 2**AW 32-bit words.

Ports:
hclk  input  1  bus clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
ahb_sel  input  1  slave select
ahb_addr  input  32  byte address (address phase)
ahb_write  input  1  1 = write, 0 = read
ahb_trans  input  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
ahb_size  input  3  BYTE 000, HALF 001, WORD 010
ahb_burst  input  3  burst type; accepted, not used for decode
ahb_wdata  input  32  write data (data phase)
ahb_readyi  input  1  bus-level HREADY (previous transfer complete)
ahb_readyo  output  1  slave ready
ahb_resp  output  2  00 OKAY, 01 ERROR
ahb_rdata  output  32  read data
sram_cs  output  1  SRAM chip select
sram_we  output  1  SRAM write enable
sram_be  output  4  byte enables, bit n = byte lane n
sram_addr  output  AW  SRAM word address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid cycle after cs & !we

Behaviour:
- Accept condition: ahb_sel & ahb_readyi & ahb_trans[1]. IDLE/BUSY/unselected transfers get OKAY, zero wait, no SRAM access.
- Reset values: ahb_readyo=1, ahb_resp=00, ahb_rdata=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0, state IDLE.
- Reset mid-operation: the pending write is dropped and the deferred read is abandoned. The next cycle after reset release is IDLE.
- Word address = ahb_addr[AW+1:2].
- Byte enables:
  - BYTE: 1 << addr[1:0].
  - HALF: addr[1] ? 1100 : 0011.
  - WORD: 1111.
  - Reads always fetch the full word.
- States:
  - IDLE: no data phase pending.
  - WR: write data phase.
  - RD: read data phase, data valid.
  - STALL: deferred read being issued.
  - ERR1, ERR2: only with the optional feature.
- Read accepted while state is not WR:
  - Same cycle: sram_cs=1, sram_we=0, sram_addr driven combinationally from ahb_addr.
  - Next state RD: ahb_readyo=1, ahb_rdata=sram_rdata.
- Write accepted:
  - Register word address and byte enables.
  - Next state WR: sram_cs=1, sram_we=1, sram_be/sram_addr from registers, sram_wdata=ahb_wdata, ahb_readyo=1.
- Read accepted while in WR (port collision):
  - Register the read address.
  - Next state STALL: ahb_readyo=0, SRAM read issued from the registered address.
  - Then RD: ahb_readyo=1 with data.
  - The write always completes before the read, so read-after-write to the same address returns the new data.
- Write accepted in WR or RD: back-to-back, no wait.
- ahb_rdata is 0 outside RD.
- No new transfer is accepted while ahb_readyo=0, because ahb_readyi is low.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined: an accepted transfer is rejected if any of these hold:
  - ahb_addr[31:AW+2] is nonzero.
  - HALF with addr[0]=1.
  - WORD with addr[1:0]≠0.
  - ahb_size > WORD.
- Rejected transfers get a two-cycle ERROR response:
  - ERR1: ahb_readyo=0, ahb_resp=01.
  - ERR2: ahb_readyo=1, ahb_resp=01.
  - No SRAM access in either cycle.
- Not defined:
  - Upper address bits are ignored (aliasing).
  - Misaligned low bits are ignored by the byte-enable rules.
  - Sizes above WORD are treated as WORD.
  - ahb_resp is tied to 00.

Test Plan:
- Assert rst for 3 cycles, release -> ahb_readyo=1, ahb_resp=00, sram_cs=0, ahb_rdata=0.
- WORD write 0x0000_0010 / 0xDEADBEEF, IDLE, then read 0x10 -> write cycle shows sram_addr=4, be=1111, we=1; read has ahb_readyo high throughout and returns 0xDEADBEEF.
- Write 0x20 / 0x12345678 with NONSEQ read 0x20 in its data phase -> ahb_readyo low exactly one cycle, then ahb_rdata=0x12345678.
- BYTE write 0x13 / 0xAA000000, then HALF write 0x10 / 0x0000BBBB, then read 0x10 -> be 1000 then 0011; read returns 0xAA00BBBB over prior contents 0.
- With AHB_SRAM_ERR_EN, read 0x0000_1000 (AW=10) -> ERR1/ERR2 sequence, no sram_cs. Without it -> aliases to word 0, OKAY.
- Assert rst during STALL -> ahb_readyo=1 next cycle, no SRAM read issued; BUSY/ahb_sel=0 transfers -> no sram_cs, OKAY.

Source files
------------

// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite bus signals between master and SRAM slave
interface ahb_sram_if;
  logic        ahb_sel;
  logic [31:0] ahb_addr;
  logic        ahb_write;
  logic [1:0]  ahb_trans;
  logic [2:0]  ahb_size;
  logic [2:0]  ahb_burst;
  logic [31:0] ahb_wdata;
  logic        ahb_readyi;
  logic        ahb_readyo;
  logic [1:0]  ahb_resp;
  logic [31:0] ahb_rdata;

  modport master (
    output ahb_sel, ahb_addr, ahb_write, ahb_trans, ahb_size, ahb_burst,
           ahb_wdata, ahb_readyi,
    input  ahb_readyo, ahb_resp, ahb_rdata
  );

  modport slave (
    input  ahb_sel, ahb_addr, ahb_write, ahb_trans, ahb_size, ahb_burst,
           ahb_wdata, ahb_readyi,
    output ahb_readyo, ahb_resp, ahb_rdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave bridging to a 1-cycle-latency single-port SRAM
// Optional macro AHB_SRAM_ERR_EN: reject out-of-range, misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int AW = 10
) (
  input  logic          hclk,
  input  logic          rst,
  ahb_sram_if.slave     bus,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_STALL, S_ERR1, S_ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] rd_addr_q;
  logic [3:0]    wr_be_q;
  logic          readyo_q;
  logic [1:0]    resp_q;

  logic          accept;
  logic          reject;
  logic          rd_acc;
  logic          wr_acc;
  logic [AW-1:0] addr_word;
  logic [3:0]    be_dec;
  logic          unused_bits;

  assign addr_word = bus.ahb_addr[AW+1:2];
  // Gating with rst keeps the combinational SRAM read path quiet while in reset.
  assign accept    = !rst && bus.ahb_sel && bus.ahb_readyi && bus.ahb_trans[1];

`ifdef AHB_SRAM_ERR_EN
  logic bad;
  always_comb begin
    bad = (bus.ahb_addr[31:AW+2] != '0) || (bus.ahb_size > 3'b010);
    if (bus.ahb_size == 3'b001 && bus.ahb_addr[0])
      bad = 1'b1;
    if (bus.ahb_size == 3'b010 && bus.ahb_addr[1:0] != 2'b00)
      bad = 1'b1;
  end
  assign reject = accept && bad;
`else
  assign reject = 1'b0;
`endif

  assign wr_acc = accept && !reject && bus.ahb_write;
  assign rd_acc = accept && !reject && !bus.ahb_write;

  always_comb begin
    case (bus.ahb_size)
      3'b000:  be_dec = 4'b0001 << bus.ahb_addr[1:0];
      3'b001:  be_dec = bus.ahb_addr[1] ? 4'b1100 : 4'b0011;
      default: be_dec = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (reject)
      state_nxt = S_ERR1;
    else if (wr_acc)
      state_nxt = S_WR;
    else if (rd_acc)
      state_nxt = (state == S_WR) ? S_STALL : S_RD;
    else if (state == S_STALL)
      state_nxt = S_RD;
    else if (state == S_ERR1)
      state_nxt = S_ERR2;
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      readyo_q  <= 1'b1;
      resp_q    <= 2'b00;
      wr_addr_q <= '0;
      wr_be_q   <= 4'b0000;
      rd_addr_q <= '0;
    end else begin
      state    <= state_nxt;
      readyo_q <= !(state_nxt == S_STALL || state_nxt == S_ERR1);
`ifdef AHB_SRAM_ERR_EN
      resp_q   <= (state_nxt == S_ERR1 || state_nxt == S_ERR2) ? 2'b01 : 2'b00;
`else
      resp_q   <= 2'b00;
`endif
      if (wr_acc) begin
        wr_addr_q <= addr_word;
        wr_be_q   <= be_dec;
      end
      // The SRAM port is busy with the write, so the read address waits a cycle.
      if (rd_acc && state == S_WR)
        rd_addr_q <= addr_word;
    end
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state == S_WR) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = wr_be_q;
      sram_addr  = wr_addr_q;
      sram_wdata = bus.ahb_wdata;
    end else if (state == S_STALL) begin
      sram_cs   = 1'b1;
      sram_be   = 4'b1111;
      sram_addr = rd_addr_q;
    end else if (rd_acc) begin
      sram_cs   = 1'b1;
      sram_be   = 4'b1111;
      sram_addr = addr_word;
    end
  end

  assign bus.ahb_readyo = readyo_q;
  assign bus.ahb_resp   = resp_q;
  assign bus.ahb_rdata  = (state == S_RD) ? sram_rdata : 32'h0;

  assign unused_bits = ^{bus.ahb_burst, bus.ahb_addr[31:AW+2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench for ahb_sram_slave
module tb_ahb_sram_slave;
  localparam int AW = 10;

  logic          hclk;
  logic          rst;
  logic          sram_cs;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  ahb_sram_if bus ();

  ahb_sram_slave #(.AW(AW)) dut (
    .hclk       (hclk),
    .rst        (rst),
    .bus        (bus),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // single slave: bus-level HREADY is this slave's ready
  always_comb bus.ahb_readyi = bus.ahb_readyo;

  logic [31:0] mem [1024] = '{default: 32'h0};
  always @(posedge hclk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef enum {P_NONE, P_WR, P_RD} pk_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  logic [31:0] exp_q [$];
  pk_t         pend_kind = P_NONE;
  logic        pend_err = 1'b0;
  logic [31:0] pend_wdata = 32'h0;
  logic [AW-1:0] pend_waddr = '0;
  logic [3:0]  pend_be = 4'h0;
  int          last_waits = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] be_of(input logic [2:0] size, input logic [31:0] a);
    case (size)
      3'b000:  be_of = 4'b0001 << a[1:0];
      3'b001:  be_of = a[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic bad_of(input logic [2:0] size, input logic [31:0] a);
`ifdef AHB_SRAM_ERR_EN
    bad_of = (a[31:AW+2] != '0) || (size > 3'b010) ||
             (size == 3'b001 && a[0]) || (size == 3'b010 && a[1:0] != 2'b00);
`else
    bad_of = 1'b0;
`endif
  endfunction

  // One address phase; the loop also checks the data phase of the previous transfer.
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic acc, e, cur_acc, exp_cs, done;
    logic [31:0] mask;
    int waits;
    bus.ahb_sel   = sel;
    bus.ahb_trans = trans;
    bus.ahb_write = wr;
    bus.ahb_size  = size;
    bus.ahb_addr  = addr;
    bus.ahb_burst = 3'b001;
    bus.ahb_wdata = (pend_kind == P_WR) ? pend_wdata : 32'h0;
    acc   = sel && trans[1];
    e     = acc && bad_of(size, addr);
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge hclk);
      cur_acc = acc && bus.ahb_readyo;
      exp_cs  = (pend_kind == P_WR) ||
                (!bus.ahb_readyo && !pend_err && pend_kind == P_RD) ||
                (cur_acc && !wr && !e);
      check("sram_cs", {31'h0, sram_cs}, {31'h0, exp_cs});
      check("resp", {30'h0, bus.ahb_resp}, pend_err ? 32'h1 : 32'h0);
      if (pend_kind == P_WR) begin
        check("sram_we", {31'h0, sram_we}, 32'h1);
        check("sram_be", {28'h0, sram_be}, {28'h0, pend_be});
        check("sram_addr", {22'h0, sram_addr}, {22'h0, pend_waddr});
        check("sram_wdata", sram_wdata, pend_wdata);
      end
      if (pend_kind == P_RD && !pend_err && bus.ahb_readyo) begin
        if (exp_q.size() == 0) check("rd_underflow", 32'h1, 32'h0);
        else check("rdata", bus.ahb_rdata, exp_q.pop_front());
      end else begin
        check("rdata_zero", bus.ahb_rdata, 32'h0);
      end
      if (bus.ahb_readyo) done = 1'b1;
      else waits++;
    end
    if (!done) check("ready_timeout", 32'h0, 32'h1);
    @(posedge hclk);
    #1;
    last_waits = waits;
    pend_err   = 1'b0;
    pend_kind  = P_NONE;
    if (acc) begin
      pend_kind = wr ? P_WR : P_RD;
      pend_err  = e;
      if (wr && !e) begin
        pend_wdata = wdata;
        pend_waddr = addr[AW+1:2];
        pend_be    = be_of(size, addr);
        mask = {{8{pend_be[3]}}, {8{pend_be[2]}}, {8{pend_be[1]}}, {8{pend_be[0]}}};
        ref_mem[addr[AW+1:2]] = (ref_mem[addr[AW+1:2]] & ~mask) | (wdata & mask);
      end else if (!wr && !e) begin
        exp_q.push_back(ref_mem[addr[AW+1:2]]);
      end
    end
  endtask

  task automatic idle();
    xfer(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.ahb_sel = 1'b0; bus.ahb_addr = 32'h0; bus.ahb_write = 1'b0;
    bus.ahb_trans = 2'b00; bus.ahb_size = 3'b010; bus.ahb_burst = 3'b000;
    bus.ahb_wdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1 rst = 1'b0;
    @(negedge hclk);
    check("rst_readyo", {31'h0, bus.ahb_readyo}, 32'h1);
    check("rst_resp", {30'h0, bus.ahb_resp}, 32'h0);
    check("rst_cs", {31'h0, sram_cs}, 32'h0);
    check("rst_rdata", bus.ahb_rdata, 32'h0);
    @(posedge hclk); #1;

    // word write, idle, read back with no wait state
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0010, 32'hDEADBEEF);
    idle();
    xfer(1, 2'b10, 0, 3'b010, 32'h0000_0010, 32'h0);
    idle();
    check("rd_nowait", last_waits, 0);

    // read in the data phase of a write to the same address
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0020, 32'h12345678);
    xfer(1, 2'b10, 0, 3'b010, 32'h0000_0020, 32'h0);
    idle();
    check("collide_waits", last_waits, 1);

    // sub-word writes merging into a cleared word
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0010, 32'h0);
    xfer(1, 2'b10, 1, 3'b000, 32'h0000_0013, 32'hAA000000);
    xfer(1, 2'b10, 1, 3'b001, 32'h0000_0010, 32'h0000BBBB);
    xfer(1, 2'b10, 0, 3'b010, 32'h0000_0010, 32'h0);
    idle();

    // back-to-back mix: WR->WR, WR->read stall, RD->RD
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0030, 32'h0BAD_F00D);
    xfer(1, 2'b11, 1, 3'b001, 32'h0000_0036, 32'h7777_1234);
    xfer(1, 2'b11, 0, 3'b010, 32'h0000_0030, 32'h0);
    xfer(1, 2'b11, 0, 3'b010, 32'h0000_0034, 32'h0);
    xfer(1, 2'b11, 0, 3'b010, 32'h0000_0030, 32'h0);
    idle();
    check("rd_rd_nowait", last_waits, 0);

    // out-of-range read: ERROR with the option, aliasing to word 0 without it
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0000, 32'h5A5A_0001);
    idle();
    xfer(1, 2'b10, 0, 3'b010, 32'h0000_1000, 32'h0);
    idle();
`ifdef AHB_SRAM_ERR_EN
    check("err_waits", last_waits, 1);
`else
    check("alias_waits", last_waits, 0);
`endif
    idle();

    // reset while a deferred read is stalled
    xfer(1, 2'b10, 1, 3'b010, 32'h0000_0040, 32'hCAFE_0040);
    bus.ahb_sel = 1; bus.ahb_trans = 2'b10; bus.ahb_write = 0;
    bus.ahb_size = 3'b010; bus.ahb_addr = 32'h0000_0040; bus.ahb_wdata = pend_wdata;
    @(negedge hclk);
    check("rs_wr_cs", {31'h0, sram_cs}, 32'h1);
    @(posedge hclk); #1;
    bus.ahb_sel = 0; bus.ahb_trans = 2'b00;
    @(negedge hclk);
    check("rs_stall_ready", {31'h0, bus.ahb_readyo}, 32'h0);
    rst = 1'b1;
    #1;
    check("rs_rst_ready", {31'h0, bus.ahb_readyo}, 32'h1);
    check("rs_rst_cs", {31'h0, sram_cs}, 32'h0);
    @(posedge hclk); #1;
    check("rs_hold_cs", {31'h0, sram_cs}, 32'h0);
    @(negedge hclk);
    rst = 1'b0;
    @(negedge hclk);
    check("rs_post_ready", {31'h0, bus.ahb_readyo}, 32'h1);
    check("rs_post_cs", {31'h0, sram_cs}, 32'h0);
    check("rs_post_rdata", bus.ahb_rdata, 32'h0);
    @(posedge hclk); #1;
    pend_kind = P_NONE;
    pend_err  = 1'b0;
    exp_q.delete();

    // BUSY and unselected transfers touch nothing
    xfer(1, 2'b01, 0, 3'b010, 32'h0000_0010, 32'h0);
    xfer(0, 2'b10, 0, 3'b010, 32'h0000_0010, 32'h0);
    xfer(0, 2'b10, 1, 3'b010, 32'h0000_0010, 32'hFFFF_FFFF);
    idle();
    xfer(1, 2'b10, 0, 3'b010, 32'h0000_0040, 32'h0);
    idle();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
